// File: rtl/program_loader.sv
// Instruction-memory loader: packs UART bytes big-endian into 32-bit words and writes them to
// consecutive addresses until the halt word. Optional inter-byte timeout: define LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int                  NB_DATA        = 32,
  parameter int                  NB_ADDR        = 7,
  parameter logic [NB_DATA-1:0]  HALT_WORD      = 32'hFFFF_FFFF,
  parameter int                  TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_done_i,
  output logic               en_write_o,
  output logic [NB_ADDR-1:0] addr_write_o,
  output logic [NB_DATA-1:0] data_write_o,
  output logic               loading_o,
  output logic               done_o,
  output logic               error_o
);

  typedef enum logic [1:0] {IDLE, RECV, DONE, ERROR} state_t;

  localparam logic [NB_ADDR-1:0] LAST_ADDR = {{(NB_ADDR-2){1'b1}}, 2'b00};

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [NB_ADDR-1:0]   ptr_q, ptr_d;
  logic [23:0]          word_q, word_d;
  logic                 en_q, en_d;
  logic [NB_ADDR-1:0]   addr_q, addr_d;
  logic [NB_DATA-1:0]   data_q, data_d;
  logic                 loading_q, loading_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [NB_DATA-1:0]   full_word;

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign full_word = {word_q, rx_data_i};

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    word_d  = word_q;
    en_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef LOADER_TIMEOUT_EN
    tmo_d   = '0;
`endif

    case (state_q)
      RECV: begin
        if (rx_done_i) begin
          word_d = full_word[23:0];
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            en_d   = 1'b1;
            addr_d = ptr_q;
            data_d = full_word;
            // Halt wins over overflow: a halt word at the last address is a clean finish.
            if (full_word == HALT_WORD)  state_d = DONE;
            else if (ptr_q == LAST_ADDR) state_d = ERROR;
            else                         ptr_d   = ptr_q + NB_ADDR'(4);
          end
        end
`ifdef LOADER_TIMEOUT_EN
        else if (cnt_q != 2'd0) begin
          if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = ERROR;
            cnt_d   = 2'd0;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
`endif
      end
      default: begin
        if (start_i) begin
          state_d = RECV;
          ptr_d   = '0;
          cnt_d   = 2'd0;
          word_d  = '0;
        end
      end
    endcase

    loading_d = (state_d == RECV);
    done_d    = (state_d == DONE);
    error_d   = (state_d == ERROR);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      ptr_q     <= '0;
      word_q    <= '0;
      en_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      word_q    <= word_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      loading_q <= loading_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef LOADER_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign en_write_o   = en_q;
  assign addr_write_o = addr_q;
  assign data_write_o = data_q;
  assign loading_o    = loading_q;
  assign done_o       = done_q;
  assign error_o      = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (default build, timeout feature disabled).
module tb_program_loader;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_done_i = 1'b0;
  logic       en_write_o;
  logic [6:0] addr_write_o;
  logic [31:0] data_write_o;
  logic       loading_o, done_o, error_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
    logic        done;
    logic        error;
  } wr_t;

  wr_t wr_q[$];

  program_loader dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .rx_data_i    (rx_data_i),
    .rx_done_i    (rx_done_i),
    .en_write_o   (en_write_o),
    .addr_write_o (addr_write_o),
    .data_write_o (data_write_o),
    .loading_o    (loading_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clock_i = ~clock_i;

  // Each write pulse spans exactly one negedge, so every write is logged once.
  always @(negedge clock_i) begin
    if (en_write_o) wr_q.push_back('{addr_write_o, data_write_o, done_o, error_o});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i = b;
    rx_done_i = 1'b1;
    tick(1);
    rx_done_i = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},      {31'd0, en_write_o}, 32'd0);
    check({tag, "_addr"},    {25'd0, addr_write_o}, 32'd0);
    check({tag, "_data"},    data_write_o, 32'd0);
    check({tag, "_loading"}, {31'd0, loading_o}, 32'd0);
    check({tag, "_done"},    {31'd0, done_o}, 32'd0);
    check({tag, "_error"},   {31'd0, error_o}, 32'd0);
  endtask

  initial begin
    // Reset state
    tick(3);
    check_reset_outputs("reset");
    reset_i = 1'b0;
    tick(1);

    // Basic load with idle gaps between bytes, then halt
    pulse_start();
    check("start_loading", {31'd0, loading_o}, 32'd1);
    send_byte(8'h20); tick(1);
    send_byte(8'h08); tick(1);
    send_byte(8'h00); tick(1);
    send_byte(8'h05); tick(2);
    send_word(32'hFFFF_FFFF);
    tick(3);
    check("basic_nwrites", wr_q.size(), 32'd2);
    if (wr_q.size() == 2) begin
      check("basic_w0_addr", {25'd0, wr_q[0].addr}, 32'd0);
      check("basic_w0_data", wr_q[0].data, 32'h2008_0005);
      check("basic_w0_done", {31'd0, wr_q[0].done}, 32'd0);
      check("basic_w1_addr", {25'd0, wr_q[1].addr}, 32'd4);
      check("basic_w1_data", wr_q[1].data, 32'hFFFF_FFFF);
      check("basic_w1_done", {31'd0, wr_q[1].done}, 32'd1);
    end
    check("basic_done", {31'd0, done_o}, 32'd1);
    check("basic_loading", {31'd0, loading_o}, 32'd0);

    // Bytes in DONE ignored; start mid-word ignored; back-to-back overlap with write pulse
    wr_q.delete();
    send_word(32'h1234_5678);
    tick(2);
    check("done_ignore_rx", wr_q.size(), 32'd0);
    check("done_sticky", {31'd0, done_o}, 32'd1);
    pulse_start();
    check("restart_done_clr", {31'd0, done_o}, 32'd0);
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    tick(2);
    check("overlap_nwrites", wr_q.size(), 32'd2);
    if (wr_q.size() == 2) begin
      check("overlap_w0_addr", {25'd0, wr_q[0].addr}, 32'd0);
      check("overlap_w0_data", wr_q[0].data, 32'h0102_0304);
      check("overlap_w1_addr", {25'd0, wr_q[1].addr}, 32'd4);
      check("overlap_w1_data", wr_q[1].data, 32'h1122_3344);
    end

    // Reset mid-word discards the partial word
    wr_q.delete();
    send_byte(8'h55);
    send_byte(8'h66);
    reset_i = 1'b1;
    tick(1);
    check_reset_outputs("midreset");
    reset_i = 1'b0;
    send_byte(8'h77);
    send_byte(8'h88);
    tick(1);
    check("idle_ignore_rx", wr_q.size(), 32'd0);
    pulse_start();
    send_word(32'hAABB_CCDD);
    tick(2);
    check("after_reset_nwrites", wr_q.size(), 32'd1);
    if (wr_q.size() == 1) begin
      check("after_reset_addr", {25'd0, wr_q[0].addr}, 32'd0);
      check("after_reset_data", wr_q[0].data, 32'hAABB_CCDD);
    end

    // Overflow: 32 non-halt words fill memory, then ERROR
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    wr_q.delete();
    pulse_start();
    for (int i = 0; i < 32; i++) send_word(32'h0100_0000 | i);
    tick(2);
    check("ovf_nwrites", wr_q.size(), 32'd32);
    if (wr_q.size() == 32) begin
      for (int i = 0; i < 32; i++) begin
        check($sformatf("ovf_addr_%0d", i), {25'd0, wr_q[i].addr}, 32'(4 * i));
        check($sformatf("ovf_data_%0d", i), wr_q[i].data, 32'h0100_0000 | i);
      end
      check("ovf_err_at_last", {31'd0, wr_q[31].error}, 32'd1);
      check("ovf_err_before_last", {31'd0, wr_q[30].error}, 32'd0);
    end
    check("ovf_error", {31'd0, error_o}, 32'd1);
    check("ovf_loading", {31'd0, loading_o}, 32'd0);
    send_word(32'h0200_0000);
    tick(2);
    check("ovf_no_33rd", wr_q.size(), 32'd32);
    check("ovf_sticky", {31'd0, error_o}, 32'd1);

    // Restart from ERROR
    wr_q.delete();
    pulse_start();
    check("restart_err_clr", {31'd0, error_o}, 32'd0);
    send_word(32'hDEAD_BEEF);
    tick(2);
    check("restart_nwrites", wr_q.size(), 32'd1);
    if (wr_q.size() == 1) begin
      check("restart_addr", {25'd0, wr_q[0].addr}, 32'd0);
      check("restart_data", wr_q[0].data, 32'hDEAD_BEEF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer side of the instruction-memory programming port.
- Collects a byte stream from the UART receiver, packs each 4 bytes into one 32-bit instruction, and writes the words to consecutive instruction-memory addresses.
- Stops when it writes the halt word, then flags completion so the debug unit can release the pipeline.
- Sits between the UART rx block and the fetch stage's write port.

Parameters:
- NB_DATA, 32, instruction width in bits; must be 32.
- NB_ADDR, 7, instruction-memory byte-address width (matches pc width).
- HALT_WORD, 32'hFFFF_FFFF, instruction value that terminates loading.
- TIMEOUT_CYCLES, 1_000_000, inter-byte timeout (used only with the optional feature).

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  pulse: begin a new load at address 0
- rx_data_i  in  8  received byte
- rx_done_i  in  1  one-cycle strobe: rx_data_i valid
- en_write_o  out  1  instruction-memory write enable, one-cycle pulse
- addr_write_o  out  NB_ADDR  byte address of the word being written
- data_write_o  out  NB_DATA  instruction word being written
- loading_o  out  1  high while in RECV
- done_o  out  1  high in DONE (halt word written)
- error_o  out  1  high in ERROR (memory overflow or timeout)

Behaviour:
- One clock; reset is synchronous and active-high on clock_i/reset_i. All outputs are registered.
- Reset values:
  - State IDLE.
  - en_write_o=0, addr_write_o=0, data_write_o=0.
  - loading_o=0, done_o=0, error_o=0.
  - Byte counter and write pointer cleared.
- States: IDLE, RECV, DONE, ERROR.
- IDLE:
  - rx_done_i is ignored.
  - start_i=1 -> RECV; write pointer=0, byte count=0.
- RECV byte packing:
  - Each rx_done_i shifts rx_data_i into the word register, first byte = bits 31:24 (big-endian).
  - The byte counter increments mod 4.
- RECV word write:
  - On the edge that accepts the 4th byte, in the following cycle: en_write_o=1 for exactly 1 cycle, addr_write_o=write pointer, data_write_o=assembled word.
  - The pointer then advances by 4.
- Overlap: a byte strobed during the en_write_o cycle is accepted as byte 0 of the next word; no byte is ever dropped.
- Halt: if the written word equals HALT_WORD, the word is still written and the state goes to DONE in the same cycle as the write pulse.
- Overflow:
  - Capacity is 2^NB_ADDR/4 words (32 by default).
  - If a non-halt word is written at the last address (124), the pointer does not wrap; the state goes to ERROR.
- DONE / ERROR:
  - Sticky; rx_done_i is ignored.
  - start_i restarts the load exactly as from IDLE and clears done_o/error_o.
- start_i while in RECV is ignored.
- Reset mid-load: return to IDLE next edge; the partial word is discarded; no write is issued.
- loading_o=1 iff state is RECV.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - In RECV with byte count≠0, a counter increments each cycle without rx_done_i and clears on rx_done_i.
  - When it reaches TIMEOUT_CYCLES-1: partial word discarded, state goes to ERROR, error_o=1, no write issued.
  - A byte count of 0 never times out.
- Undefined: no counter is synthesized; a partial word waits indefinitely.

Test Plan:
- Reset, start, send bytes 20 08 00 05 then FF FF FF FF -> write 0x20080005 at addr 0, then write 0xFFFFFFFF at addr 4; done_o=1 from the cycle of the second write; exactly 2 en_write_o pulses.
- Send a byte in the same cycle en_write_o is high (bytes back-to-back every cycle) -> no byte lost; second word is correct at addr 4.
- Send 32 non-halt words -> writes at addr 0..124; error_o=1 after the 32nd write; no 33rd write; then start_i -> error_o=0, addr restarts at 0.
- Reset asserted after 2 bytes of a word -> outputs return to reset values; after start, 4 new bytes AA BB CC DD -> 0xAABBCCDD at addr 0.
- rx_done_i pulses in IDLE and DONE -> no en_write_o; start_i pulse in RECV mid-word -> ignored; word completes normally.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: send 3 bytes, then idle 16 cycles -> error_o=1 and no write. Idle 100 cycles with 0 bytes pending -> no error.
